fifo_ptr_ctrl_256x256: RTL

Pointer and access controller for the single-port 256x256 line/frame FIFO in the median-filter datapath. It arbitrates producer push requests against consumer pop requests and drives the `ff_en`/`ff_push_pop` request pair into the FIFO status logic. It accepts the returned `ff_we`/`ff_re`/`ff_cs` grants, owns the write and read pointers (MSB wrap bit included), and presents the single-port RAM address and strobes. It also tracks occupancy and frame completion.

---
 rtl/median_fifo_pkg.sv | 13 +
 rtl/fifo_rw_arbiter.sv | 51 +++++
 rtl/fifo_ptr_ctrl_256x256.sv | 88 ++++++++
 3 files changed

// File: rtl/median_fifo_pkg.sv
// Shared constants for the median-filter line/frame FIFO: geometry and
// the push/pop encoding of the ff_push_pop request line.
package median_fifo_pkg;

    localparam int ADDR_WIDTH   = 16;
    localparam int FRAME_PIXELS = 65536;

    typedef enum logic {
        OP_POP  = 1'b0,
        OP_PUSH = 1'b1
    } op_e;

endpackage

// File: rtl/fifo_rw_arbiter.sv
// Push/pop arbiter: combinational selection between producer and consumer,
// with a round-robin prio_rd flag for contested cycles.
module fifo_rw_arbiter
    import median_fifo_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic wr_req,
    input  logic rd_req,
    input  logic full_signal,
    input  logic empty_signal,
    input  logic ff_we,
    input  logic ff_re,
    output logic ff_en,
    output logic ff_push_pop
);

    op_e  sel_op;
    logic contested;
    logic forced;
    logic prio_rd_q;
    logic prio_rd_d;

    assign contested = wr_req & rd_req;
    // Full/empty dictate the winner; such cycles leave the round-robin alone.
    assign forced    = contested & (full_signal | empty_signal);

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        sel_op    = OP_POP;
        prio_rd_d = prio_rd_q;
        if (contested) begin
            if (full_signal)       sel_op = OP_POP;
            else if (empty_signal) sel_op = OP_PUSH;
            else                   sel_op = prio_rd_q ? OP_POP : OP_PUSH;
        end else if (wr_req) begin
            sel_op = OP_PUSH;
        end
        if (contested && !forced && (ff_we || ff_re)) prio_rd_d = ~prio_rd_q;
    end

    assign ff_en       = wr_req | rd_req;
    assign ff_push_pop = (sel_op == OP_PUSH);

    // NOTE: state registers use non-blocking assignment only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prio_rd_q <= 1'b0;
        else        prio_rd_q <= prio_rd_d;
    end

endmodule

// File: rtl/fifo_ptr_ctrl_256x256.sv
// Pointer/access controller for the single-port 256x256 median-filter FIFO:
// owns the wrap-bit pointers, occupancy, read-valid and frame-done pulse.
module fifo_ptr_ctrl_256x256 #(
    parameter int ADDR_WIDTH = median_fifo_pkg::ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_req,
    input  logic                  rd_req,
    output logic                  wr_ack,
    output logic                  rd_ack,
    output logic                  rd_valid,
    output logic                  ff_en,
    output logic                  ff_push_pop,
    input  logic                  ff_we,
    input  logic                  ff_re,
    input  logic                  ff_cs,
    input  logic                  full_signal,
    input  logic                  empty_signal,
    output logic [ADDR_WIDTH:0]   wptr,
    output logic [ADDR_WIDTH:0]   rptr,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  ram_re,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  frame_done
);

    logic [ADDR_WIDTH:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                rd_valid_q, rd_valid_d;
    logic                frame_done_q, frame_done_d;

    fifo_rw_arbiter u_arbiter (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .full_signal  (full_signal),
        .empty_signal (empty_signal),
        .ff_we        (ff_we),
        .ff_re        (ff_re),
        .ff_en        (ff_en),
        .ff_push_pop  (ff_push_pop)
    );

    assign wr_ack   = ff_we;
    assign rd_ack   = ff_re;
    assign ram_we   = ff_we & ff_cs;
    assign ram_re   = ff_re & ff_cs;
    assign ram_addr = (ff_push_pop == median_fifo_pkg::OP_PUSH) ?
                      wptr_q[ADDR_WIDTH-1:0] : rptr_q[ADDR_WIDTH-1:0];

    always_comb begin
        wptr_d       = wptr_q + {{ADDR_WIDTH{1'b0}}, ff_we};
        rptr_d       = rptr_q + {{ADDR_WIDTH{1'b0}}, ff_re};
        count_d      = count_q + {{ADDR_WIDTH{1'b0}}, ff_we} - {{ADDR_WIDTH{1'b0}}, ff_re};
        // Pulse marks the push that fills the last address of a frame.
        frame_done_d = ff_we & (&wptr_q[ADDR_WIDTH-1:0]);
        rd_valid_d   = ram_re;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            rd_valid_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            rd_valid_q   <= rd_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign wptr       = wptr_q;
    assign rptr       = rptr_q;
    assign count      = count_q;
    assign rd_valid   = rd_valid_q;
    assign frame_done = frame_done_q;

    one_op_per_cycle: assert property (@(posedge clk) disable iff (!rst_n) !(ff_we && ff_re));

endmodule
